register_file_2r1w: RTL and testbench
=====================================

Name: register_file_2r1w

Overview:
- Parametrised successor to the team's fixed 16x16 combinational register-read mux.
- Adds storage, a synchronous write port, two independent registered read ports with write-through bypass, an optional hardwired-zero register 0, and a per-register "written" tracking mask.
- Sits between the decode stage (source addresses) and the ALU/writeback path (destination address/data) of the microprocessor datapath.

Parameters:
- WIDTH, 16, data bits per register (>=1).
- DEPTH, 16, number of registers; must be a power of two, >=2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- ZERO_REG, 0, when 1 register 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  WIDTH  write data.
- ra_en  input  1  read port A request.
- ra_addr  input  ADDR_W  read port A address.
- ra_data  output  WIDTH  read port A data (registered).
- ra_valid  output  1  high for exactly one cycle when ra_data carries fresh read.
- rb_en  input  1  read port B request.
- rb_addr  input  ADDR_W  read port B address.
- rb_data  output  WIDTH  read port B data (registered).
- rb_valid  output  1  read port B fresh-data strobe.
- clear_mask  input  1  synchronous clear of written_mask.
- written_mask  output  DEPTH  bit i set once register i has been written since reset/clear.

Behaviour:
- Reset (async, level): all DEPTH registers, ra_data, rb_data, ra_valid, rb_valid, written_mask = 0. Held while reset high; first edge after deassertion operates normally.
- Write: on rising edge with we=1, reg[waddr] <= wdata. If ZERO_REG=1 and waddr=0, write is dropped: reg0 stays 0 and mask bit 0 stays 0.
- Read latency: exactly 1 cycle. ra_en=1 sampled at edge N -> ra_data/ra_valid updated at edge N, visible during cycle N+1. Port B is identical and fully independent.
- When ra_en=0 at an edge: ra_valid <= 0; ra_data holds its previous value.
- Bypass: if we=1, waddr==ra_addr and ra_en=1 in the same cycle, ra_data <= wdata (new value, write-first). No bypass when the ZERO_REG drop applies; the read returns 0.
- ZERO_REG=1: any read of address 0 returns 0 regardless of history.
- Both ports may read the same address, and both may hit the bypass, in the same cycle; each returns the identical value.
- written_mask:
  - A performed write to address i sets bit i at the edge.
  - clear_mask=1 clears all bits at the edge.
  - clear_mask and a write together: all bits clear except waddr, which is set (write wins).
- Addresses are full-range; no out-of-range case exists because DEPTH=2^ADDR_W.
- Reset asserted mid-operation: any in-flight read is discarded (valid forced 0); any write in that cycle is lost.
- Registers must be implemented as a 2-D array with generate loops; no hard-coded per-register gates.

Test Plan:
1. Reset, then read A addr 5 and read B addr 15 -> next cycle ra_data=0, rb_data=0, both valid=1, written_mask=0.
2. Write 0xBEEF to reg 3; next cycle ra_en addr 3 -> following cycle ra_data=0xBEEF, ra_valid=1; ra_en=0 next cycle -> ra_valid=0, ra_data stays 0xBEEF; written_mask=0x0008.
3. Same-cycle write 0x1234 to reg 7 with ra_addr=7 and rb_addr=7 enabled -> next cycle ra_data=rb_data=0x1234 (bypass); reg 7 then reads 0x1234.
4. ZERO_REG=1: write 0xFFFF to reg 0 with ra_addr=0 -> ra_data=0, written_mask bit 0 stays 0. ZERO_REG=0: same stimulus -> ra_data=0xFFFF, mask bit 0 set.
5. Mask already 0x0008; clear_mask=1 together with a write to reg 9 -> written_mask=0x0200.
6. WIDTH=32, DEPTH=32: write 0xDEADBEEF to reg 31, then assert reset for half a cycle during a pending read -> ra_valid=0, all outputs 0; post-reset read of reg 31 returns 0.

Source files
------------

// File: rtl/register_file_2r1w.sv
// Parametrised 2-read/1-write register file with registered read ports,
// write-first bypass, optional hardwired-zero r0 and a per-register written mask.
module register_file_2r1w #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter bit ZERO_REG = 1'b0,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              ra_en,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [WIDTH-1:0]  ra_data,
    output logic              ra_valid,
    input  logic              rb_en,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [WIDTH-1:0]  rb_data,
    output logic              rb_valid,
    input  logic              clear_mask,
    output logic [DEPTH-1:0]  written_mask
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_ok;
    logic [WIDTH-1:0] ra_next;
    logic [WIDTH-1:0] rb_next;

    // A write to r0 is dropped entirely when r0 is hardwired to zero.
    assign wr_ok = we && !(ZERO_REG && (waddr == '0));

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        logic [WIDTH-1:0] q;
        logic             w;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                q <= '0;
                w <= 1'b0;
            end else if (wr_ok && (waddr == ADDR_W'(i))) begin
                q <= wdata;
                w <= 1'b1;
            end else if (clear_mask) begin
                w <= 1'b0;
            end
        end

        assign regs[i]         = q;
        assign written_mask[i] = w;
    end

    // Write-first: a same-cycle write to the read address returns the new data.
    function automatic logic [WIDTH-1:0] read_value(input logic [ADDR_W-1:0] addr);
        if (ZERO_REG && (addr == '0)) begin
            return '0;
        end
        if (wr_ok && (waddr == addr)) begin
            return wdata;
        end
        return regs[addr];
    endfunction

    always_comb begin
        ra_next = read_value(ra_addr);
        rb_next = read_value(rb_addr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ra_data  <= '0;
            ra_valid <= 1'b0;
        end else begin
            ra_valid <= ra_en;
            if (ra_en) begin
                ra_data <= ra_next;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= rb_en;
            if (rb_en) begin
                rb_data <= rb_next;
            end
        end
    end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Drives three register_file_2r1w configurations (16x16, 16x16 with zero r0, 32x32)
// with shared stimulus and checks every output against an array-based model.
module tb_register_file_2r1w;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ra_en;
    logic [4:0]  ra_addr;
    logic        rb_en;
    logic [4:0]  rb_addr;
    logic        clear_mask;

    logic [15:0] ra0, rb0, wm0, ra1, rb1, wm1;
    logic [31:0] ra2, rb2, wm2;
    logic        rav0, rbv0, rav1, rbv1, rav2, rbv2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    register_file_2r1w #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b0)) u_plain (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr[3:0]), .wdata(wdata[15:0]),
        .ra_en(ra_en), .ra_addr(ra_addr[3:0]), .ra_data(ra0), .ra_valid(rav0),
        .rb_en(rb_en), .rb_addr(rb_addr[3:0]), .rb_data(rb0), .rb_valid(rbv0),
        .clear_mask(clear_mask), .written_mask(wm0)
    );

    register_file_2r1w #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b1)) u_zero (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr[3:0]), .wdata(wdata[15:0]),
        .ra_en(ra_en), .ra_addr(ra_addr[3:0]), .ra_data(ra1), .ra_valid(rav1),
        .rb_en(rb_en), .rb_addr(rb_addr[3:0]), .rb_data(rb1), .rb_valid(rbv1),
        .clear_mask(clear_mask), .written_mask(wm1)
    );

    register_file_2r1w #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b0)) u_wide (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .ra_en(ra_en), .ra_addr(ra_addr), .ra_data(ra2), .ra_valid(rav2),
        .rb_en(rb_en), .rb_addr(rb_addr), .rb_data(rb2), .rb_valid(rbv2),
        .clear_mask(clear_mask), .written_mask(wm2)
    );

    logic [31:0] obs_ra [3];
    logic [31:0] obs_rb [3];
    logic [31:0] obs_wm [3];
    logic        obs_rav [3];
    logic        obs_rbv [3];

    assign obs_ra[0] = {16'h0, ra0};
    assign obs_ra[1] = {16'h0, ra1};
    assign obs_ra[2] = ra2;
    assign obs_rb[0] = {16'h0, rb0};
    assign obs_rb[1] = {16'h0, rb1};
    assign obs_rb[2] = rb2;
    assign obs_wm[0] = {16'h0, wm0};
    assign obs_wm[1] = {16'h0, wm1};
    assign obs_wm[2] = wm2;
    assign obs_rav[0] = rav0;
    assign obs_rav[1] = rav1;
    assign obs_rav[2] = rav2;
    assign obs_rbv[0] = rbv0;
    assign obs_rbv[1] = rbv1;
    assign obs_rbv[2] = rbv2;

    // Reference model: plain arrays indexed by instance and register number.
    int          dep  [3] = '{16, 16, 32};
    bit          zr   [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] dmsk [3] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFFFFFF};
    logic [31:0] mem  [3][32];
    logic [31:0] mmask [3];
    logic [31:0] e_ra [3];
    logic [31:0] e_rb [3];
    logic        e_rav [3];
    logic        e_rbv [3];

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 32; r++) mem[k][r] = '0;
            mmask[k] = '0;
            e_ra[k]  = '0;
            e_rb[k]  = '0;
            e_rav[k] = 1'b0;
            e_rbv[k] = 1'b0;
        end
    endtask

    function automatic logic [31:0] model_read(int k, int a, bit wrote, int wa);
        if (zr[k] && a == 0) return 32'h0;
        if (wrote && wa == a) return wdata & dmsk[k];
        return mem[k][a];
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int wa;
            int a;
            int b;
            bit wrote;
            wa    = int'(waddr) % dep[k];
            a     = int'(ra_addr) % dep[k];
            b     = int'(rb_addr) % dep[k];
            wrote = we && !(zr[k] && wa == 0);
            e_rav[k] = ra_en;
            e_rbv[k] = rb_en;
            if (ra_en) e_ra[k] = model_read(k, a, wrote, wa);
            if (rb_en) e_rb[k] = model_read(k, b, wrote, wa);
            if (wrote) mem[k][wa] = wdata & dmsk[k];
            if (clear_mask) mmask[k] = '0;
            if (wrote) mmask[k][wa] = 1'b1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ra_data[%0d]", k), obs_ra[k], e_ra[k]);
            chk($sformatf("ra_valid[%0d]", k), 32'(obs_rav[k]), 32'(e_rav[k]));
            chk($sformatf("rb_data[%0d]", k), obs_rb[k], e_rb[k]);
            chk($sformatf("rb_valid[%0d]", k), 32'(obs_rbv[k]), 32'(e_rbv[k]));
            chk($sformatf("written_mask[%0d]", k), obs_wm[k], mmask[k]);
        end
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0;
        ra_en = 1'b0; ra_addr = '0;
        rb_en = 1'b0; rb_addr = '0;
        clear_mask = 1'b0;
    endtask

    // Inputs are set after a falling edge; outputs are checked 1 ns after the rising edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        model_clear();
        #2;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Reads right after reset return zero with valid set.
        ra_en = 1'b1; ra_addr = 5'd5; rb_en = 1'b1; rb_addr = 5'd15;
        cycle();
        chk("t1_ra_zero", obs_ra[0], 32'h0);
        chk("t1_rav", 32'(obs_rav[0]), 32'd1);

        // Write, read next cycle, then valid drops while data holds.
        idle(); we = 1'b1; waddr = 5'd3; wdata = 32'h0000BEEF;
        cycle();
        idle(); ra_en = 1'b1; ra_addr = 5'd3;
        cycle();
        chk("t2_ra_beef", obs_ra[0], 32'h0000BEEF);
        idle();
        cycle();
        chk("t2_rav_low", 32'(obs_rav[0]), 32'd0);
        chk("t2_ra_hold", obs_ra[0], 32'h0000BEEF);
        chk("t2_mask", obs_wm[0], 32'h00000008);

        // Both ports hit the bypass together.
        idle(); we = 1'b1; waddr = 5'd7; wdata = 32'h00001234;
        ra_en = 1'b1; ra_addr = 5'd7; rb_en = 1'b1; rb_addr = 5'd7;
        cycle();
        chk("t3_ra_bypass", obs_ra[0], 32'h00001234);
        chk("t3_rb_bypass", obs_rb[0], 32'h00001234);
        idle(); ra_en = 1'b1; ra_addr = 5'd7;
        cycle();
        chk("t3_ra_stored", obs_ra[0], 32'h00001234);

        // Write to r0 with bypass read: dropped only when r0 is hardwired.
        idle(); we = 1'b1; waddr = 5'd0; wdata = 32'h0000FFFF; ra_en = 1'b1; ra_addr = 5'd0;
        cycle();
        chk("t4_zero_ra", obs_ra[1], 32'h0);
        chk("t4_zero_mask0", 32'(obs_wm[1][0]), 32'd0);
        chk("t4_plain_ra", obs_ra[0], 32'h0000FFFF);
        chk("t4_plain_mask0", 32'(obs_wm[0][0]), 32'd1);

        // Clear together with a write leaves only the written bit.
        idle(); clear_mask = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h00005A5A;
        cycle();
        chk("t5_mask", obs_wm[0], 32'h00000200);

        // Randomised traffic with a bias toward bypass hits and r0 accesses.
        for (int n = 0; n < 400; n++) begin
            idle();
            we         = ($urandom_range(0, 1) == 1);
            waddr      = 5'($urandom);
            wdata      = $urandom;
            ra_en      = ($urandom_range(0, 3) != 0);
            rb_en      = ($urandom_range(0, 3) != 0);
            ra_addr    = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            rb_addr    = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            clear_mask = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 15) == 0) waddr = 5'd0;
            if ($urandom_range(0, 15) == 0) ra_addr = 5'd0;
            cycle();
        end

        // Reset during a pending read discards it and wipes stored data.
        idle(); we = 1'b1; waddr = 5'd31; wdata = 32'hDEADBEEF;
        cycle();
        idle(); ra_en = 1'b1; ra_addr = 5'd31;
        reset = 1'b1;
        model_clear();
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all();
        chk("t6_rav_dropped", 32'(obs_rav[2]), 32'd0);
        @(negedge clk);
        idle(); ra_en = 1'b1; ra_addr = 5'd31;
        cycle();
        chk("t6_ra_after_reset", obs_ra[2], 32'h0);
        chk("t6_rav_after_reset", 32'(obs_rav[2]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
